fetch_queue_stage: RTL and testbench
====================================

Name: fetch_queue_stage

Overview:
- Parametrised successor to the single-register fetch stage.
- Holds the PC and drives a combinational instruction-memory read port.
- Assembles opcode words, plus an optional following immediate word, into entries in a DEPTH-deep prefetch queue.
- Presents queue entries to decode with a valid/ready handshake, which decouples fetch from decode stalls.
- Sits between instruction memory and the decode stage; a PC redirect from the write-back/branch path flushes it.

Parameters:
ADDR_W, 32, PC and memory address width
INSTR_W, 16, instruction word width (also immediate width)
DEPTH, 4, queue entries (power of two, >=2)
RESET_PC, 32, PC value after reset (first instruction-memory address)
IMM_FLAG_BIT, 15, opcode bit which, when 1, means the next word is an immediate
NOP_INSTR, 0, instruction value driven when the queue is empty

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_addr  out  ADDR_W  instruction memory address (= current PC)
imem_data  in  INSTR_W  word at imem_addr, same cycle (combinational read)
redirect  in  1  load PC from redirect_pc and flush the queue
redirect_pc  in  ADDR_W  new PC value
out_ready  in  1  decode accepts the head entry (low = decode stall)
out_valid  out  1  head entry valid
out_instr  out  INSTR_W  head opcode word (NOP_INSTR when empty)
out_imm  out  INSTR_W  head immediate (0 if none)
out_has_imm  out  1  head entry carries an immediate
out_pc_plus_one  out  ADDR_W  address following the head entry's last word
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (async, any state): PC=RESET_PC, state=S_OP, queue empty (rd_ptr=wr_ptr=0, count=0), opcode holding register=0.
  - Outputs at reset: out_valid=0, out_instr=NOP_INSTR, out_imm=0, out_has_imm=0, out_pc_plus_one=0, count=0.
- pop = out_valid & out_ready. can_push = (count<DEPTH) | pop. Push and pop may occur in the same cycle, including when the queue is full.
- FSM states:
  - S_OP: if can_push, latch imem_data as the opcode.
    - If imem_data[IMM_FLAG_BIT]=0: push {opcode, imm=0, has_imm=0, pc_plus_one=PC+1}; PC<=PC+1; stay in S_OP.
    - If imem_data[IMM_FLAG_BIT]=1: hold the opcode; PC<=PC+1; go to S_IMM; no push this cycle.
    - If !can_push: PC holds, no state change.
  - S_IMM: if can_push, push {held opcode, imem_data, has_imm=1, pc_plus_one=PC+1}; PC<=PC+1; go to S_OP. Otherwise hold.
- Redirect has highest priority:
  - Next edge: PC<=redirect_pc, queue emptied, state=S_OP, no push.
  - A pop in the same cycle is ignored by the queue, and decode must also discard it.
  - Redirect while in S_IMM drops the half-assembled entry.
- Head outputs are driven combinationally from the queue at rd_ptr. Entries become visible one cycle after the push edge; there is no bypass.
- Pipeline latencies:
  - Fetch-to-valid latency: 1 cycle for a single-word instruction, 2 cycles for a two-word instruction.
  - After redirect or reset: first out_valid is 1 cycle later for a single-word instruction, 2 cycles later for a two-word instruction.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. PC arithmetic is modulo 2^ADDR_W (PC=all ones wraps to 0).
- count updates each edge: +1 on push only, -1 on pop only, unchanged on both or neither; reset to 0 on redirect.
- out_ready ignored when out_valid=0. The queue never overflows or underflows.

Decomposition:
- Package fetch_pkg holds:
  - enum fetch_state_t {S_OP, S_IMM}
  - struct fetch_entry_t {instr, imm, has_imm, pc_plus_one}, parametrised via widths supplied as localparams
  - NOP encoding constant
- One sub-module: fetch_fifo, a generic DEPTH-entry FIFO with synchronous flush, push/pop, count and full/empty outputs.
- The top level holds the PC, the FSM and entry assembly.

Test Plan:
- Reset then release, memory returns 0x0001,0x0002,0x0003 at addresses 32,33,34, out_ready=1 -> imem_addr=32 after reset; out_instr 0x0001/0x0002/0x0003 on consecutive cycles; out_pc_plus_one 33/34/35.
- Word 0x8005 at 32, 0x1234 at 33 -> one entry: out_instr=0x8005, out_imm=0x1234, out_has_imm=1, out_pc_plus_one=34; out_valid rises 2 cycles after reset release.
- out_ready=0 with single-word stream -> count climbs to 4; imem_addr freezes at 36; raising out_ready for 1 cycle pops 0x0001 and the same edge pushes the word at 36 (count stays 4).
- Full queue and redirect=1, redirect_pc=0x100 -> next cycle count=0, out_valid=0, imem_addr=0x100; first entry from 0x100 appears the following cycle.
- Redirect asserted while in S_IMM (opcode 0x8005 held) -> held opcode discarded; no entry with instr 0x8005 ever appears.
- Assert reset mid-stream with count=3 -> immediately out_valid=0, count=0, imem_addr=32, all head outputs at their reset values.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch queue stage: FSM state encoding, queue entry
// layout and the instruction value presented when the queue is empty.
package fetch_pkg;

   localparam int FETCH_ADDR_W  = 32;
   localparam int FETCH_INSTR_W = 16;

   localparam logic [FETCH_INSTR_W-1:0] FETCH_NOP = '0;

   typedef enum logic [0:0] {
      S_OP  = 1'b0,
      S_IMM = 1'b1
   } fetch_state_t;

   // Entry fields are sized by the package widths; the stage parameters
   // must not exceed them.
   typedef struct packed {
      logic [FETCH_INSTR_W-1:0] instr;
      logic [FETCH_INSTR_W-1:0] imm;
      logic                     has_imm;
      logic [FETCH_ADDR_W-1:0]  pc_plus_one;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH-entry FIFO with synchronous flush, simultaneous push/pop
// (also when full) and a combinational head read.
module fetch_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign do_push = push & (~full | do_pop);

   assign dout  = mem_reg[rd_ptr_reg];
   assign count = count_reg;

   // Storage carries no reset so it can map onto distributed RAM.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem_reg[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            count_reg <= count_reg + CNT_W'(1);
         end else if (do_pop && !do_push) begin
            count_reg <= count_reg - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage with a prefetch queue: walks the PC, assembles opcode(+imm)
// entries from instruction memory and hands them to decode via valid/ready.
module fetch_queue_stage
   import fetch_pkg::*;
#(
   parameter  int                 ADDR_W       = FETCH_ADDR_W,
   parameter  int                 INSTR_W      = FETCH_INSTR_W,
   parameter  int                 DEPTH        = 4,
   parameter  logic [ADDR_W-1:0]  RESET_PC     = ADDR_W'(32),
   parameter  int                 IMM_FLAG_BIT = 15,
   parameter  logic [INSTR_W-1:0] NOP_INSTR    = INSTR_W'(FETCH_NOP),
   localparam int                 CNT_W        = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [INSTR_W-1:0] out_instr,
   output logic [INSTR_W-1:0] out_imm,
   output logic               out_has_imm,
   output logic [ADDR_W-1:0]  out_pc_plus_one,
   output logic [CNT_W-1:0]   count
);

   fetch_state_t       state_reg, state_next;
   logic [ADDR_W-1:0]  pc_reg, pc_next, pc_inc;
   logic [INSTR_W-1:0] op_reg, op_next;
   fetch_entry_t       push_entry, head_entry;
   logic               push, pop, can_push;
   logic               fifo_full, fifo_empty;

   assign pc_inc    = pc_reg + ADDR_W'(1);
   assign imem_addr = pc_reg;
   assign pop       = out_valid & out_ready;
   assign can_push  = ~fifo_full | pop;

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      op_next    = op_reg;
      push       = 1'b0;
      push_entry = '0;
      if (redirect) begin
         // Any half-assembled opcode is abandoned along with the queue.
         pc_next    = redirect_pc;
         state_next = S_OP;
      end else if (can_push) begin
         case (state_reg)
            S_OP: begin
               op_next = imem_data;
               pc_next = pc_inc;
               if (imem_data[IMM_FLAG_BIT]) begin
                  state_next = S_IMM;
               end else begin
                  push                   = 1'b1;
                  push_entry.instr       = FETCH_INSTR_W'(imem_data);
                  push_entry.pc_plus_one = FETCH_ADDR_W'(pc_inc);
               end
            end
            S_IMM: begin
               push                   = 1'b1;
               push_entry.instr       = FETCH_INSTR_W'(op_reg);
               push_entry.imm         = FETCH_INSTR_W'(imem_data);
               push_entry.has_imm     = 1'b1;
               push_entry.pc_plus_one = FETCH_ADDR_W'(pc_inc);
               pc_next                = pc_inc;
               state_next             = S_OP;
            end
            default: state_next = S_OP;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_reg    <= RESET_PC;
         state_reg <= S_OP;
         op_reg    <= '0;
      end else begin
         pc_reg    <= pc_next;
         state_reg <= state_next;
         op_reg    <= op_next;
      end
   end

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (reset),
      .flush (redirect),
      .push  (push),
      .din   (push_entry),
      .pop   (pop & ~redirect),
      .dout  (head_entry),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Stale storage is masked so an empty queue always shows the idle values.
   assign out_valid       = ~fifo_empty;
   assign out_instr       = fifo_empty ? NOP_INSTR : INSTR_W'(head_entry.instr);
   assign out_imm         = fifo_empty ? '0 : INSTR_W'(head_entry.imm);
   assign out_has_imm     = ~fifo_empty & head_entry.has_imm;
   assign out_pc_plus_one = fifo_empty ? '0 : ADDR_W'(head_entry.pc_plus_one);

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: queue-level reference model
// compared every cycle, plus directed literal expectations.
module tb_fetch_queue_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] imem_addr;
   logic [15:0] imem_data;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [15:0] out_instr;
   logic [15:0] out_imm;
   logic        out_has_imm;
   logic [31:0] out_pc_plus_one;
   logic [2:0]  count;

   logic [15:0] mem [1024];

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] imm;
      logic        has_imm;
      logic [31:0] pc1;
   } m_entry_t;

   m_entry_t    m_q[$];
   logic [31:0] m_pc = 32'd32;
   bit          m_half = 1'b0;
   logic [15:0] m_op = '0;
   bit          watch_8005 = 1'b0;
   bit          seen_8005 = 1'b0;

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr[9:0]];

   fetch_queue_stage #(
      .ADDR_W       (32),
      .INSTR_W      (16),
      .DEPTH        (4),
      .RESET_PC     (32'd32),
      .IMM_FLAG_BIT (15),
      .NOP_INSTR    (16'h0000)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .out_ready       (out_ready),
      .out_valid       (out_valid),
      .out_instr       (out_instr),
      .out_imm         (out_imm),
      .out_has_imm     (out_has_imm),
      .out_pc_plus_one (out_pc_plus_one),
      .count           (count)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference: the queue holds whole instructions; each edge decode may take
   // the head, and fetch consumes one memory word if room exists afterwards.
   task automatic model_step();
      bit          took;
      bit          room;
      logic [15:0] w;
      m_entry_t    e;
      if (reset) begin
         m_q.delete();
         m_pc   = 32'd32;
         m_half = 1'b0;
         m_op   = '0;
      end else if (redirect) begin
         m_q.delete();
         m_pc   = redirect_pc;
         m_half = 1'b0;
      end else begin
         took = (m_q.size() != 0) && out_ready;
         room = (m_q.size() < 4) || took;
         w    = mem[m_pc[9:0]];
         if (took) void'(m_q.pop_front());
         if (room) begin
            if (m_half) begin
               e = '{instr: m_op, imm: w, has_imm: 1'b1, pc1: m_pc + 32'd1};
               m_q.push_back(e);
               m_half = 1'b0;
            end else if (w[15]) begin
               m_op   = w;
               m_half = 1'b1;
            end else begin
               e = '{instr: w, imm: 16'h0, has_imm: 1'b0, pc1: m_pc + 32'd1};
               m_q.push_back(e);
            end
            m_pc = m_pc + 32'd1;
         end
      end
   endtask

   initial forever begin
      @(posedge clk or posedge reset);
      model_step();
   end

   task automatic compare_model();
      m_entry_t h;
      chk("cmp_valid", 32'(out_valid), 32'(m_q.size() != 0));
      chk("cmp_count", 32'(count), 32'(m_q.size()));
      chk("cmp_addr", imem_addr, m_pc);
      if (m_q.size() != 0) begin
         h = m_q[0];
      end else begin
         h = '{instr: 16'h0, imm: 16'h0, has_imm: 1'b0, pc1: 32'h0};
      end
      chk("cmp_instr", 32'(out_instr), 32'(h.instr));
      chk("cmp_imm", 32'(out_imm), 32'(h.imm));
      chk("cmp_has_imm", 32'(out_has_imm), 32'(h.has_imm));
      chk("cmp_pc1", out_pc_plus_one, h.pc1);
      if (watch_8005 && out_valid && out_instr == 16'h8005) seen_8005 = 1'b1;
   endtask

   // One cycle: compare on the falling edge, return just after the rising edge.
   task automatic tick();
      @(negedge clk);
      compare_model();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      foreach (mem[i]) mem[i] = 16'h0;
   endtask

   initial begin
      // Single-word stream
      clear_mem();
      mem[32] = 16'h0001; mem[33] = 16'h0002; mem[34] = 16'h0003;
      out_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;
      chk("t1_addr_reset", imem_addr, 32'd32);
      chk("t1_valid_reset", 32'(out_valid), 32'd0);
      tick();
      chk("t1_instr0", 32'(out_instr), 32'h0001);
      chk("t1_pc1_0", out_pc_plus_one, 32'd33);
      tick();
      chk("t1_instr1", 32'(out_instr), 32'h0002);
      chk("t1_pc1_1", out_pc_plus_one, 32'd34);
      tick();
      chk("t1_instr2", 32'(out_instr), 32'h0003);
      chk("t1_pc1_2", out_pc_plus_one, 32'd35);

      // Two-word instruction
      clear_mem();
      mem[32] = 16'h8005; mem[33] = 16'h1234;
      reset = 1'b1; tick(); reset = 1'b0;
      tick();
      chk("t2_valid_1cyc", 32'(out_valid), 32'd0);
      tick();
      chk("t2_valid_2cyc", 32'(out_valid), 32'd1);
      chk("t2_instr", 32'(out_instr), 32'h8005);
      chk("t2_imm", 32'(out_imm), 32'h1234);
      chk("t2_has_imm", 32'(out_has_imm), 32'd1);
      chk("t2_pc1", out_pc_plus_one, 32'd34);

      // Decode stall fills the queue, then simultaneous push/pop when full
      clear_mem();
      for (int i = 0; i < 16; i++) mem[32 + i] = 16'(i + 1);
      out_ready = 1'b0;
      reset = 1'b1; tick(); reset = 1'b0;
      repeat (5) tick();
      chk("t3_count_full", 32'(count), 32'd4);
      chk("t3_addr_frozen", imem_addr, 32'd36);
      chk("t3_head", 32'(out_instr), 32'h0001);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("t3_count_pushpop", 32'(count), 32'd4);
      chk("t3_head_after", 32'(out_instr), 32'h0002);
      chk("t3_addr_adv", imem_addr, 32'd37);

      // Redirect on a full queue
      mem[256] = 16'h0042;
      redirect = 1'b1; redirect_pc = 32'h100; tick();
      redirect = 1'b0; out_ready = 1'b1;
      chk("t4_count", 32'(count), 32'd0);
      chk("t4_valid", 32'(out_valid), 32'd0);
      chk("t4_addr", imem_addr, 32'h100);
      tick();
      chk("t4_first_valid", 32'(out_valid), 32'd1);
      chk("t4_first_instr", 32'(out_instr), 32'h0042);
      chk("t4_first_pc1", out_pc_plus_one, 32'h101);

      // Redirect while an opcode waits for its immediate
      mem[512] = 16'h8005; mem[513] = 16'h7777;
      mem[768] = 16'h0011; mem[769] = 16'h0012;
      watch_8005 = 1'b1;
      redirect = 1'b1; redirect_pc = 32'h200; tick(); redirect = 1'b0;
      tick();
      chk("t5_half_valid", 32'(out_valid), 32'd0);
      chk("t5_half_addr", imem_addr, 32'h201);
      redirect = 1'b1; redirect_pc = 32'h300; tick(); redirect = 1'b0;
      chk("t5_count", 32'(count), 32'd0);
      chk("t5_addr", imem_addr, 32'h300);
      tick();
      chk("t5_instr", 32'(out_instr), 32'h0011);
      repeat (3) tick();
      watch_8005 = 1'b0;
      chk("t5_no_8005", 32'(seen_8005), 32'd0);

      // PC wrap at all ones
      mem[1023] = 16'h0009;
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; tick(); redirect = 1'b0;
      chk("t6_addr_max", imem_addr, 32'hFFFF_FFFF);
      tick();
      chk("t6_instr", 32'(out_instr), 32'h0009);
      chk("t6_pc1_wrap", out_pc_plus_one, 32'h0);
      chk("t6_addr_wrap", imem_addr, 32'h0);

      // Asynchronous reset mid-stream
      clear_mem();
      for (int i = 0; i < 16; i++) mem[32 + i] = 16'(i + 1);
      out_ready = 1'b0;
      reset = 1'b1; tick(); reset = 1'b0;
      repeat (3) tick();
      chk("t7_count3", 32'(count), 32'd3);
      reset = 1'b1;
      #1;
      chk("t7_valid", 32'(out_valid), 32'd0);
      chk("t7_count", 32'(count), 32'd0);
      chk("t7_addr", imem_addr, 32'd32);
      chk("t7_instr", 32'(out_instr), 32'h0);
      chk("t7_imm", 32'(out_imm), 32'h0);
      chk("t7_has_imm", 32'(out_has_imm), 32'd0);
      chk("t7_pc1", out_pc_plus_one, 32'h0);
      tick();
      reset = 1'b0;
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
